// File: rtl/search_engine_nbank.sv
// Store-and-search engine: entries are striped across BANKS data banks plus one
// address memory. A search scans one row (BANKS entries) per cycle, first match wins.

module search_engine_nbank_lane #(
    parameter int DW = 8,
    parameter int IW = 7
) (
    input  logic [DW-1:0] i_key,
    input  logic [DW-1:0] i_data,
    input  logic [IW-1:0] i_idx,
    input  logic [IW:0]   i_count,
    input  logic          i_mask_en,
    input  logic [IW-1:0] i_mask_idx,
    output logic          o_match
);
    logic w_valid;

    // Masked lanes are entries already reported by a previous find-next step.
    assign w_valid = ({1'b0, i_idx} < i_count) && !(i_mask_en && (i_idx <= i_mask_idx));
    assign o_match = w_valid && (i_data == i_key);
endmodule

module search_engine_nbank #(
    parameter  int DW    = 8,
    parameter  int AW    = 8,
    parameter  int DEPTH = 128,
    parameter  int BANKS = 2,
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] wr_addr,
    output logic          wr_ready,
    input  logic          srch_start,
    input  logic [DW-1:0] srch_key,
    input  logic          srch_next,
    input  logic          srch_ack,
    output logic          busy,
    output logic          done,
    output logic          hit,
    output logic [IW-1:0] hit_index,
    output logic [AW-1:0] hit_addr,
    output logic [IW:0]   count,
    output logic          full
);
    localparam int LB   = $clog2(BANKS);
    localparam int RW   = IW - LB;
    localparam int ROWS = DEPTH / BANKS;

    typedef enum logic [1:0] {IDLE, SCAN, RESULT} state_t;

    state_t          r_state, w_nxt_state;
    logic [DW-1:0]   r_key, w_nxt_key;
    logic [RW-1:0]   r_row, w_nxt_row;
    logic            r_mask_en, w_nxt_mask_en;
    logic [IW-1:0]   r_mask_idx, w_nxt_mask_idx;
    logic [IW:0]     r_count, w_nxt_count;
    logic            r_busy, w_nxt_busy;
    logic            r_done, w_nxt_done;
    logic            r_hit, w_nxt_hit;
    logic [IW-1:0]   r_hit_index, w_nxt_hit_index;
    logic [AW-1:0]   r_hit_addr, w_nxt_hit_addr;

    logic [AW-1:0]   r_amem [DEPTH];

    logic            w_full, w_wr_fire;
    logic [IW:0]     w_wr_lane, w_cnt_m1;
    logic [IW-1:0]   w_row_base, w_win_idx;
    logic [BANKS-1:0] w_match;
    logic            w_found;
    logic            w_last_row;

    assign w_full    = (r_count == (IW+1)'(DEPTH));
    assign wr_ready  = (r_state == IDLE) && !w_full && !srch_start;
    assign w_wr_fire = wr_en && wr_ready && !clr;
    assign w_wr_lane = r_count & (IW+1)'(BANKS - 1);
    assign w_cnt_m1  = r_count - 1'b1;
    assign w_row_base = IW'(r_row) << LB;
    assign w_last_row = ((IW+1)'(r_row) == (w_cnt_m1 >> LB));

    always_ff @(posedge clk) begin
        if (w_wr_fire)
            r_amem[r_count[IW-1:0]] <= wr_addr;
    end

    // One bank and one comparator per lane; lane b holds entries with index%BANKS == b.
    genvar b;
    generate
        for (b = 0; b < BANKS; b++) begin : g_lane
            logic [DW-1:0] r_mem [ROWS];
            logic [IW-1:0] w_idx;

            always_ff @(posedge clk) begin
                if (w_wr_fire && (w_wr_lane == (IW+1)'(b)))
                    r_mem[r_count[IW-1:LB]] <= wr_data;
            end

            assign w_idx = w_row_base | IW'(b);

            search_engine_nbank_lane #(.DW(DW), .IW(IW)) u_lane (
                .i_key      (r_key),
                .i_data     (r_mem[r_row]),
                .i_idx      (w_idx),
                .i_count    (r_count),
                .i_mask_en  (r_mask_en),
                .i_mask_idx (r_mask_idx),
                .o_match    (w_match[b])
            );
        end
    endgenerate

    // Descending scan so the lowest matching lane is the one left standing.
    always_comb begin
        w_found   = 1'b0;
        w_win_idx = w_row_base;
        for (int i = BANKS - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_found   = 1'b1;
                w_win_idx = w_row_base | IW'(i);
            end
        end
    end

    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_key       = r_key;
        w_nxt_row       = r_row;
        w_nxt_mask_en   = r_mask_en;
        w_nxt_mask_idx  = r_mask_idx;
        w_nxt_count     = r_count + (IW+1)'(w_wr_fire);
        w_nxt_busy      = r_busy;
        w_nxt_done      = 1'b0;
        w_nxt_hit       = r_hit;
        w_nxt_hit_index = r_hit_index;
        w_nxt_hit_addr  = r_hit_addr;

        if (clr) begin
            w_nxt_state     = IDLE;
            w_nxt_count     = '0;
            w_nxt_busy      = 1'b0;
            w_nxt_hit       = 1'b0;
            w_nxt_hit_index = '0;
            w_nxt_hit_addr  = '0;
        end else if (srch_start && (r_state != SCAN)) begin
            w_nxt_key       = srch_key;
            w_nxt_row       = '0;
            w_nxt_mask_en   = 1'b0;
            w_nxt_mask_idx  = '0;
            w_nxt_hit       = 1'b0;
            w_nxt_hit_index = '0;
            w_nxt_hit_addr  = '0;
            if (r_count == '0) begin
                w_nxt_state = IDLE;
                w_nxt_done  = 1'b1;
                w_nxt_busy  = 1'b0;
            end else begin
                w_nxt_state = SCAN;
                w_nxt_busy  = 1'b1;
            end
        end else begin
            case (r_state)
                SCAN: begin
                    if (w_found) begin
                        w_nxt_state     = RESULT;
                        w_nxt_hit       = 1'b1;
                        w_nxt_hit_index = w_win_idx;
                        w_nxt_hit_addr  = r_amem[w_win_idx];
                        w_nxt_done      = 1'b1;
                        w_nxt_busy      = 1'b0;
                    end else if (w_last_row) begin
                        w_nxt_state     = IDLE;
                        w_nxt_hit       = 1'b0;
                        w_nxt_hit_index = '0;
                        w_nxt_hit_addr  = '0;
                        w_nxt_done      = 1'b1;
                        w_nxt_busy      = 1'b0;
                    end else begin
                        w_nxt_row = r_row + 1'b1;
                    end
                end
                RESULT: begin
                    if (srch_next) begin
                        if ((IW+1)'(r_hit_index) == w_cnt_m1) begin
                            w_nxt_state     = IDLE;
                            w_nxt_hit       = 1'b0;
                            w_nxt_hit_index = '0;
                            w_nxt_hit_addr  = '0;
                            w_nxt_done      = 1'b1;
                        end else begin
                            w_nxt_state    = SCAN;
                            w_nxt_row      = r_hit_index[IW-1:LB];
                            w_nxt_mask_en  = 1'b1;
                            w_nxt_mask_idx = r_hit_index;
                            w_nxt_busy     = 1'b1;
                        end
                    end else if (srch_ack) begin
                        w_nxt_state = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_key       <= '0;
            r_row       <= '0;
            r_mask_en   <= 1'b0;
            r_mask_idx  <= '0;
            r_count     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_hit       <= 1'b0;
            r_hit_index <= '0;
            r_hit_addr  <= '0;
        end else begin
            r_state     <= w_nxt_state;
            r_key       <= w_nxt_key;
            r_row       <= w_nxt_row;
            r_mask_en   <= w_nxt_mask_en;
            r_mask_idx  <= w_nxt_mask_idx;
            r_count     <= w_nxt_count;
            r_busy      <= w_nxt_busy;
            r_done      <= w_nxt_done;
            r_hit       <= w_nxt_hit;
            r_hit_index <= w_nxt_hit_index;
            r_hit_addr  <= w_nxt_hit_addr;
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign hit       = r_hit;
    assign hit_index = r_hit_index;
    assign hit_addr  = r_hit_addr;
    assign count     = r_count;
    assign full      = w_full;
endmodule

// File: tb/tb_search_engine_nbank.sv
// Directed bench for search_engine_nbank (BANKS=2, DEPTH=128): table of searches
// over a five-entry store plus hand sequences for find-next, clear, fill and reset.

module tb_search_engine_nbank;
    localparam int DW = 8, AW = 8, DEPTH = 128, BANKS = 2, IW = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clr = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic [AW-1:0] wr_addr = '0;
    logic          wr_ready;
    logic          srch_start = 1'b0;
    logic [DW-1:0] srch_key = '0;
    logic          srch_next = 1'b0;
    logic          srch_ack = 1'b0;
    logic          busy, done, hit, full;
    logic [IW-1:0] hit_index;
    logic [AW-1:0] hit_addr;
    logic [IW:0]   count;

    int checks = 0;
    int failures = 0;

    search_engine_nbank #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .BANKS(BANKS)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .wr_en(wr_en), .wr_data(wr_data), .wr_addr(wr_addr), .wr_ready(wr_ready),
        .srch_start(srch_start), .srch_key(srch_key), .srch_next(srch_next),
        .srch_ack(srch_ack), .busy(busy), .done(done), .hit(hit),
        .hit_index(hit_index), .hit_addr(hit_addr), .count(count), .full(full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] key;
        int         edges;
        logic       hit;
        logic [6:0] idx;
        logic [7:0] addr;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [7:0] d, input logic [7:0] a);
        wr_en = 1'b1; wr_data = d; wr_addr = a;
        tick();
        wr_en = 1'b0;
    endtask

    // Called just after the edge that sampled the request; counts edges until done.
    task automatic wait_done(output int edges, output bit busy_ok);
        edges = 1;
        busy_ok = 1'b1;
        while (!done && edges < 200) begin
            if (!busy) busy_ok = 1'b0;
            tick();
            edges++;
        end
    endtask

    task automatic search(input logic [7:0] key, output int edges, output bit busy_ok);
        srch_key = key; srch_start = 1'b1;
        tick();
        srch_start = 1'b0;
        wait_done(edges, busy_ok);
    endtask

    task automatic next_step(output int edges, output bit busy_ok);
        srch_next = 1'b1;
        tick();
        srch_next = 1'b0;
        wait_done(edges, busy_ok);
    endtask

    task automatic ack();
        srch_ack = 1'b1;
        tick();
        srch_ack = 1'b0;
    endtask

    initial begin
        vec_t tbl[5];
        logic [7:0] dat[5];
        int  e;
        bit  bok;
        bit  seen;

        dat[0] = 8'd10; dat[1] = 8'd20; dat[2] = 8'd30; dat[3] = 8'd20; dat[4] = 8'd40;
        tbl[0] = '{key: 8'd20, edges: 2, hit: 1'b1, idx: 7'd1, addr: 8'hA1};
        tbl[1] = '{key: 8'd10, edges: 2, hit: 1'b1, idx: 7'd0, addr: 8'hA0};
        tbl[2] = '{key: 8'd30, edges: 3, hit: 1'b1, idx: 7'd2, addr: 8'hA2};
        tbl[3] = '{key: 8'd40, edges: 4, hit: 1'b1, idx: 7'd4, addr: 8'hA4};
        tbl[4] = '{key: 8'd99, edges: 4, hit: 1'b0, idx: 7'd0, addr: 8'h00};

        // Reset state
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hit", hit, 0);
        chk("rst_count", count, 0);
        chk("rst_hit_index", hit_index, 0);
        chk("rst_hit_addr", hit_addr, 0);
        chk("rst_wr_ready", wr_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) write(dat[i], 8'hA0 + 8'(i));
        chk("count5", count, 5);

        // Table of searches over the five-entry store
        for (int i = 0; i < 5; i++) begin
            search(tbl[i].key, e, bok);
            chk($sformatf("t%0d_done", i), done, 1);
            chk($sformatf("t%0d_latency", i), e, tbl[i].edges);
            chk($sformatf("t%0d_busy_during_scan", i), bok, 1);
            chk($sformatf("t%0d_busy_after", i), busy, 0);
            chk($sformatf("t%0d_hit", i), hit, tbl[i].hit);
            chk($sformatf("t%0d_index", i), hit_index, tbl[i].idx);
            chk($sformatf("t%0d_addr", i), hit_addr, tbl[i].addr);
            if (tbl[i].hit) begin
                chk($sformatf("t%0d_result_wr_ready", i), wr_ready, 0);
                ack();
                chk($sformatf("t%0d_ack_idle", i), wr_ready, 1);
                chk($sformatf("t%0d_ack_hit_held", i), hit, 1);
            end
            tick();
            chk($sformatf("t%0d_done_pulse", i), done, 0);
        end

        // Find-next: 20 at index 1, then index 3, then exhausted
        search(8'd20, e, bok);
        chk("n0_index", hit_index, 1);
        next_step(e, bok);
        chk("n1_done", done, 1);
        chk("n1_hit", hit, 1);
        chk("n1_index", hit_index, 3);
        chk("n1_addr", hit_addr, 8'hA3);
        next_step(e, bok);
        chk("n2_done", done, 1);
        chk("n2_hit", hit, 0);
        chk("n2_index", hit_index, 0);
        chk("n2_addr", hit_addr, 0);
        chk("n2_idle", wr_ready, 1);

        // Find-next from the last stored entry finishes without scanning
        search(8'd40, e, bok);
        chk("nl_index", hit_index, 4);
        next_step(e, bok);
        chk("nl_done", done, 1);
        chk("nl_hit", hit, 0);
        chk("nl_idle", wr_ready, 1);

        // srch_start wins over a simultaneous write
        wr_en = 1'b1; wr_data = 8'd77; wr_addr = 8'h77;
        srch_key = 8'd30; srch_start = 1'b1;
        #1;
        chk("sw_wr_ready", wr_ready, 0);
        tick();
        wr_en = 1'b0; srch_start = 1'b0;
        wait_done(e, bok);
        chk("sw_count", count, 5);
        chk("sw_index", hit_index, 2);
        ack();

        // clr in the middle of a scan
        search(8'd99, e, bok);
        srch_key = 8'd99; srch_start = 1'b1;
        tick();
        srch_start = 1'b0;
        chk("clr_busy_before", busy, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_busy", busy, 0);
        chk("clr_done", done, 0);
        chk("clr_count", count, 0);
        chk("clr_wr_ready", wr_ready, 1);
        chk("clr_hit", hit, 0);
        tick();
        chk("clr_no_late_done", done, 0);

        // Empty engine: immediate miss, never busy
        srch_key = 8'd10; srch_start = 1'b1;
        tick();
        srch_start = 1'b0;
        seen = 1'b0; bok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (busy) bok = 1'b0;
            if (done && !seen) begin
                seen = 1'b1;
                chk("empty_hit", hit, 0);
            end
            tick();
        end
        chk("empty_done_seen", seen, 1);
        chk("empty_never_busy", bok, 1);

        // Fill to capacity, one extra write dropped
        for (int i = 0; i < DEPTH; i++) write(8'(i), 8'(i) ^ 8'h5A);
        chk("fill_full", full, 1);
        chk("fill_wr_ready", wr_ready, 0);
        write(8'd200, 8'hFF);
        chk("fill_count", count, 128);
        search(8'd127, e, bok);
        chk("f127_latency", e, 65);
        chk("f127_hit", hit, 1);
        chk("f127_index", hit_index, 127);
        chk("f127_addr", hit_addr, 8'd127 ^ 8'h5A);
        chk("f127_busy_during_scan", bok, 1);
        ack();

        // Asynchronous reset mid-scan
        srch_key = 8'd250; srch_start = 1'b1;
        tick();
        srch_start = 1'b0;
        tick(); tick();
        chk("ar_busy_before", busy, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_busy", busy, 0);
        chk("ar_hit", hit, 0);
        chk("ar_count", count, 0);
        chk("ar_done", done, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("ar_no_done", done, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
